// File: rtl/vram_responder_if.sv
// VRAM pin bundle between the PPU-side BB buffers and the responder.
// Signal names keep the responder's view: *_i are driven by the PPU side, *_o by the responder.
interface vram_responder_if;
  logic        vrd_n_i;
  logic        vawr_n_i;
  logic        vbwr_n_i;
  logic        va14_i;
  logic [13:0] vaa_i;
  logic [13:0] vab_i;
  logic [7:0]  vda_i;
  logic [7:0]  vdb_i;
  logic [7:0]  vda_o;
  logic [7:0]  vdb_o;
  logic        vd_tristate_o;
  logic        lvl_vd_dir_o;

  modport master (
    output vrd_n_i, vawr_n_i, vbwr_n_i, va14_i, vaa_i, vab_i, vda_i, vdb_i,
    input  vda_o, vdb_o, vd_tristate_o, lvl_vd_dir_o
  );

  modport slave (
    input  vrd_n_i, vawr_n_i, vbwr_n_i, va14_i, vaa_i, vab_i, vda_i, vdb_i,
    output vda_o, vdb_o, vd_tristate_o, lvl_vd_dir_o
  );
endinterface

// File: rtl/vram_responder.sv
// Emulates the two SNES VRAM chips towards the PPU: serves reads, captures writes,
// and exposes a host read port for dumping the captured contents.
module vram_responder #(
  parameter int ADDR_BITS   = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  vram_responder_if.slave      bus,
  input  logic                 host_req_i,
  input  logic                 host_sel_i,
  input  logic [ADDR_BITS-1:0] host_addr_i,
  output logic [7:0]           host_data_o,
  output logic                 host_valid_o,
  output logic [15:0]          write_count_o,
  output logic                 error_collision_o,
  output logic                 error_late_read_o
);

  typedef struct packed {
    logic        rd_n;
    logic        wa_n;
    logic        wb_n;
    logic        va14;
    logic [13:0] vaa;
    logic [13:0] vab;
    logic [7:0]  vda;
    logic [7:0]  vdb;
  } bus_sample_t;

  typedef enum logic [1:0] {IDLE, READ_FETCH, READ_DRIVE, WRITE} state_t;

  localparam bus_sample_t SYNC_RESET = '{rd_n: 1'b1, wa_n: 1'b1, wb_n: 1'b1, va14: 1'b0,
                                         vaa: '0, vab: '0, vda: '0, vdb: '0};

  bus_sample_t            w_pin;
  bus_sample_t            w_s;
  bus_sample_t            r_sync [SYNC_STAGES];
  logic                   r_prev_rd_n, r_prev_wa_n, r_prev_wb_n;
  logic [7:0]             r_prev_vda, r_prev_vdb;
  logic                   r_pend_a, r_pend_b;
  logic [ADDR_BITS-1:0]   r_waddr_a, r_waddr_b;
  logic [ADDR_BITS-1:0]   w_addr_a, w_addr_b;
  logic                   w_rd_fall, w_rd_rise, w_wa_fall, w_wa_rise, w_wb_fall, w_wb_rise;
  logic                   w_collision, w_commit_a, w_commit_b, w_issue_read;
  state_t                 r_state;
  logic [7:0]             r_vda, r_vdb, r_ram_a_q, r_ram_b_q;
  logic                   r_tristate, r_dir;
  logic [15:0]            r_count;
  logic                   r_err_col, r_err_late;
  logic                   r_host_req, r_host_sel, r_host_sel_q, r_host_valid;
  logic [ADDR_BITS-1:0]   r_host_addr;
  logic [7:0]             r_host_q_a, r_host_q_b;

  // Strobes, address and data travel through one pipeline so they stay cycle-aligned.
  assign w_pin = '{rd_n: bus.vrd_n_i, wa_n: bus.vawr_n_i, wb_n: bus.vbwr_n_i, va14: bus.va14_i,
                   vaa: bus.vaa_i, vab: bus.vab_i, vda: bus.vda_i, vdb: bus.vdb_i};
  assign w_s   = r_sync[SYNC_STAGES-1];

  // NOTE: clocked state always uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RESET;
      r_prev_rd_n <= 1'b1;
      r_prev_wa_n <= 1'b1;
      r_prev_wb_n <= 1'b1;
      r_prev_vda  <= '0;
      r_prev_vdb  <= '0;
    end else begin
      r_sync[0] <= w_pin;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev_rd_n <= w_s.rd_n;
      r_prev_wa_n <= w_s.wa_n;
      r_prev_wb_n <= w_s.wb_n;
      r_prev_vda  <= w_s.vda;
      r_prev_vdb  <= w_s.vdb;
    end
  end

  assign w_rd_fall = r_prev_rd_n & ~w_s.rd_n;
  assign w_rd_rise = ~r_prev_rd_n & w_s.rd_n;
  assign w_wa_fall = r_prev_wa_n & ~w_s.wa_n;
  assign w_wa_rise = ~r_prev_wa_n & w_s.wa_n;
  assign w_wb_fall = r_prev_wb_n & ~w_s.wb_n;
  assign w_wb_rise = ~r_prev_wb_n & w_s.wb_n;

  assign w_addr_a     = ADDR_BITS'({w_s.va14, w_s.vaa});
  assign w_addr_b     = ADDR_BITS'({w_s.va14, w_s.vab});
  assign w_collision  = ~w_s.rd_n & (~w_s.wa_n | ~w_s.wb_n);
  assign w_commit_a   = w_wa_rise & r_pend_a & w_s.rd_n;
  assign w_commit_b   = w_wb_rise & r_pend_b & w_s.rd_n;
  assign w_issue_read = w_rd_fall & ((r_state == IDLE) | (r_state == WRITE));

  // A write armed at its strobe fall is dropped if the read strobe overlaps it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_a  <= 1'b0;
      r_pend_b  <= 1'b0;
      r_waddr_a <= '0;
      r_waddr_b <= '0;
    end else begin
      if (w_collision) begin
        r_pend_a <= 1'b0;
      end else if (w_wa_fall) begin
        r_pend_a  <= 1'b1;
        r_waddr_a <= w_addr_a;
      end else if (w_wa_rise) begin
        r_pend_a <= 1'b0;
      end
      if (w_collision) begin
        r_pend_b <= 1'b0;
      end else if (w_wb_fall) begin
        r_pend_b  <= 1'b1;
        r_waddr_b <= w_addr_b;
      end else if (w_wb_rise) begin
        r_pend_b <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_vda      <= '0;
      r_vdb      <= '0;
      r_tristate <= 1'b1;
      r_dir      <= 1'b0;
      r_count    <= '0;
      r_err_col  <= 1'b0;
      r_err_late <= 1'b0;
    end else begin
      if (w_collision) r_err_col <= 1'b1;
      r_count <= r_count + 16'(w_commit_a) + 16'(w_commit_b);
      case (r_state)
        IDLE: begin
          if (w_rd_fall)                  r_state <= READ_FETCH;
          else if (w_wa_fall | w_wb_fall) r_state <= WRITE;
        end
        READ_FETCH: begin
          if (w_s.rd_n) begin
            r_err_late <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_vda      <= r_ram_a_q;
            r_vdb      <= r_ram_b_q;
            r_tristate <= 1'b0;
            r_dir      <= 1'b1;
            r_state    <= READ_DRIVE;
          end
        end
        READ_DRIVE: begin
          if (w_rd_rise) begin
            r_tristate <= 1'b1;
            r_dir      <= 1'b0;
            r_state    <= IDLE;
          end
        end
        WRITE: begin
          if (w_rd_fall)                r_state <= READ_FETCH;
          else if (w_s.wa_n & w_s.wb_n) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Host request stage: the RAM read happens one cycle later on port B.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_host_req   <= 1'b0;
      r_host_sel   <= 1'b0;
      r_host_addr  <= '0;
      r_host_sel_q <= 1'b0;
      r_host_valid <= 1'b0;
    end else begin
      r_host_req   <= host_req_i;
      r_host_sel   <= host_sel_i;
      r_host_addr  <= host_addr_i;
      r_host_sel_q <= r_host_sel;
      r_host_valid <= r_host_req;
    end
  end

  // NOTE: the RAM arrays have no reset; captured contents must survive reset_n and this
  // keeps each chip mappable onto a true dual-port block RAM.
  logic [7:0] r_mem_a [2**ADDR_BITS];
  logic [7:0] r_mem_b [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (w_commit_a)   r_mem_a[r_waddr_a] <= r_prev_vda;
    if (w_issue_read) r_ram_a_q <= r_mem_a[w_addr_a];
    if (r_host_req)   r_host_q_a <= r_mem_a[r_host_addr];
  end

  always_ff @(posedge clock) begin
    if (w_commit_b)   r_mem_b[r_waddr_b] <= r_prev_vdb;
    if (w_issue_read) r_ram_b_q <= r_mem_b[w_addr_b];
    if (r_host_req)   r_host_q_b <= r_mem_b[r_host_addr];
  end

  assign bus.vda_o         = r_vda;
  assign bus.vdb_o         = r_vdb;
  assign bus.vd_tristate_o = r_tristate;
  assign bus.lvl_vd_dir_o  = r_dir;
  assign host_data_o       = r_host_sel_q ? r_host_q_b : r_host_q_a;
  assign host_valid_o      = r_host_valid;
  assign write_count_o     = r_count;
  assign error_collision_o = r_err_col;
  assign error_late_read_o = r_err_late;

endmodule
